// File: rtl/conv_tile_sequencer.sv
// conv_tile_sequencer
//   Runs one convolution tile operation per start request: streams the input
//   tile and the kernel out of their BRAMs, packs them into the flattened
//   vectors the conv datapath consumes, pulses conv_start, waits for
//   conv_final, latches the result and pulses done/result_valid.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   start                 request an operation (sampled only in IDLE)
//   tile_base/kernel_base first BRAM addresses, sampled with start
//   busy/done             operation in flight / one-cycle completion pulse
//   result/result_valid   latched conv output / one-cycle pulse with done
//   in_en/in_addr/in_dout input BRAM read port
//   k_en/k_addr/k_dout    kernel BRAM read port
//   flat_input/flat_kernel packed vectors to the conv (first word in MS slot)
//   conv_start/conv_final/conv_out  conv handshake
//
// Optional feature: define CONV_SEQ_KERNEL_CACHE_EN to skip the kernel fetch
// when the requested kernel_base matches the last fully loaded kernel.
module conv_tile_sequencer #(
  parameter int TILE_SIZE     = 4,
  parameter int KERNEL_SIZE   = 3,
  parameter int CHANNELS      = 3,
  parameter int DATA_WIDTH    = 8,
  parameter int KERNEL_WIDTH  = 8,
  parameter int IN_ADDR_WIDTH = 15,
  parameter int K_ADDR_WIDTH  = 8,
  parameter int OUTPUT_WIDTH  = 20,
  parameter int BRAM_LATENCY  = 1,
  parameter int NI = TILE_SIZE * TILE_SIZE * CHANNELS,
  parameter int NK = KERNEL_SIZE * KERNEL_SIZE * CHANNELS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [IN_ADDR_WIDTH-1:0]   tile_base,
  input  logic [K_ADDR_WIDTH-1:0]    kernel_base,
  output logic                       busy,
  output logic                       done,
  output logic [OUTPUT_WIDTH-1:0]    result,
  output logic                       result_valid,
  output logic                       in_en,
  output logic [IN_ADDR_WIDTH-1:0]   in_addr,
  input  logic [DATA_WIDTH-1:0]      in_dout,
  output logic                       k_en,
  output logic [K_ADDR_WIDTH-1:0]    k_addr,
  input  logic [KERNEL_WIDTH-1:0]    k_dout,
  output logic [NI*DATA_WIDTH-1:0]   flat_input,
  output logic [NK*KERNEL_WIDTH-1:0] flat_kernel,
  output logic                       conv_start,
  input  logic                       conv_final,
  input  logic [OUTPUT_WIDTH-1:0]    conv_out
);

  localparam int IW = $clog2(NI);
  localparam logic [IW-1:0] LAST_I     = IW'(NI - 1);
  localparam logic [IW-1:0] NK_I       = IW'(NK);
  localparam logic [IW-1:0] NK_LAST    = IW'(NK - 1);
  localparam logic [1:0]    DRAIN_LAST = 2'(BRAM_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRAIN, S_KICK, S_COMPUTE, S_FINISH
  } state_t;

  state_t state, state_nx;

  logic [IN_ADDR_WIDTH-1:0] tbase_q;
  logic [K_ADDR_WIDTH-1:0]  kbase_q;
  logic [IW-1:0]            idx;
  logic [1:0]               dcnt;
  logic                     skip_k;

  // Two-deep valid/index delay line; the tap matching BRAM_LATENCY marks
  // the cycle in which the BRAM data for that index is present.
  logic [1:0]    vld_q;
  logic [IW-1:0] idx_q0, idx_q1;
  logic          tap_vld;
  logic [IW-1:0] tap_idx, slot_i, slot_k;

  assign tap_vld = (BRAM_LATENCY == 2) ? vld_q[1] : vld_q[0];
  assign tap_idx = (BRAM_LATENCY == 2) ? idx_q1 : idx_q0;
  assign slot_i  = LAST_I - tap_idx;
  assign slot_k  = NK_LAST - tap_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    busy         = 1'b0;
    done         = 1'b0;
    result_valid = 1'b0;
    in_en        = 1'b0;
    in_addr      = '0;
    k_en         = 1'b0;
    k_addr       = '0;
    conv_start   = 1'b0;
    case (state)
      S_IDLE: if (start) state_nx = S_LOAD;
      S_LOAD: begin
        busy    = 1'b1;
        in_en   = 1'b1;
        in_addr = tbase_q + IN_ADDR_WIDTH'(idx);
        if (idx < NK_I && !skip_k) begin
          k_en   = 1'b1;
          k_addr = kbase_q + K_ADDR_WIDTH'(idx);
        end
        if (idx == LAST_I) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (dcnt == DRAIN_LAST) state_nx = S_KICK;
      end
      S_KICK: begin
        busy       = 1'b1;
        conv_start = 1'b1;
        state_nx   = S_COMPUTE;
      end
      S_COMPUTE: begin
        busy = 1'b1;
        if (conv_final) state_nx = S_FINISH;
      end
      S_FINISH: begin
        done         = 1'b1;
        result_valid = 1'b1;
        state_nx     = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tbase_q     <= '0;
      kbase_q     <= '0;
      idx         <= '0;
      dcnt        <= '0;
      vld_q       <= '0;
      idx_q0      <= '0;
      idx_q1      <= '0;
      flat_input  <= '0;
      flat_kernel <= '0;
      result      <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        tbase_q <= tile_base;
        kbase_q <= kernel_base;
        idx     <= '0;
        dcnt    <= '0;
      end
      if (state == S_LOAD)  idx  <= idx + 1'b1;
      if (state == S_DRAIN) dcnt <= dcnt + 2'd1;
      vld_q  <= {vld_q[0], state == S_LOAD};
      idx_q0 <= idx;
      idx_q1 <= idx_q0;
      if (tap_vld) begin
        flat_input[slot_i*DATA_WIDTH +: DATA_WIDTH] <= in_dout;
        if (tap_idx < NK_I && !skip_k)
          flat_kernel[slot_k*KERNEL_WIDTH +: KERNEL_WIDTH] <= k_dout;
      end
      if (state == S_COMPUTE && conv_final) result <= conv_out;
    end
  end

`ifdef CONV_SEQ_KERNEL_CACHE_EN
  logic                    kernel_valid;
  logic [K_ADDR_WIDTH-1:0] kernel_stored;

  // The hit decision is frozen at acceptance; the cache is only marked valid
  // once DRAIN has captured the last kernel word, so an aborted load never hits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kernel_valid  <= 1'b0;
      kernel_stored <= '0;
      skip_k        <= 1'b0;
    end else begin
      if (state == S_IDLE && start)
        skip_k <= kernel_valid && (kernel_base == kernel_stored);
      if (state == S_DRAIN && dcnt == DRAIN_LAST && !skip_k) begin
        kernel_valid  <= 1'b1;
        kernel_stored <= kbase_q;
      end
    end
  end
`else
  assign skip_k = 1'b0;
`endif

endmodule

// File: tb/tb_conv_tile_sequencer.sv
module tb_conv_tile_sequencer;
  localparam int NI = 48;
  localparam int NK = 27;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, stray;
  logic [14:0]   tile_base, in_addr;
  logic [7:0]    kernel_base, k_addr, in_dout, k_dout;
  logic          busy, done, result_valid, in_en, k_en, conv_start, conv_final;
  logic [19:0]   result, conv_out, conv_val;
  logic [NI*8-1:0] flat_input;
  logic [NK*8-1:0] flat_kernel;

  conv_tile_sequencer #(.BRAM_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .start(start), .tile_base(tile_base),
    .kernel_base(kernel_base), .busy(busy), .done(done), .result(result),
    .result_valid(result_valid), .in_en(in_en), .in_addr(in_addr),
    .in_dout(in_dout), .k_en(k_en), .k_addr(k_addr), .k_dout(k_dout),
    .flat_input(flat_input), .flat_kernel(flat_kernel),
    .conv_start(conv_start), .conv_final(conv_final), .conv_out(conv_out)
  );

  // BRAM models, one cycle read latency
  always @(posedge clk) begin
    if (in_en) in_dout <= in_addr[7:0];
    if (k_en)  k_dout  <= k_addr + 8'h80;
  end

  // Conv model: conv_final high 5 cycles after conv_start
  logic       cf_model = 1'b0;
  logic [3:0] cdly = 4'd0;
  always @(posedge clk) begin
    cf_model <= 1'b0;
    if (conv_start) cdly <= 4'd1;
    else if (cdly == 4'd4) begin
      cdly     <= 4'd0;
      cf_model <= 1'b1;
    end else if (cdly != 4'd0) cdly <= cdly + 4'd1;
  end
  assign conv_final = cf_model | stray;
  assign conv_out   = conv_val;

  int n_checks = 0;
  int n_fail   = 0;

  logic [NI*8-1:0] exp_fi = '0;
  logic [NK*8-1:0] exp_fk = '0;
  bit              tb_kv = 1'b0;
  logic [7:0]      tb_kb = '0;
  logic [14:0]     exp_in_q[$];
  logic [7:0]      exp_k_q[$];

  task automatic run_op(input logic [14:0] tb, input logic [7:0] kb,
                        input logic [19:0] val, input bit hold, input bit chain);
    bit fetch;
    int cyc, first_in, kicks, kick_cyc, done_cyc;
    logic [14:0] ea;
    logic [7:0]  ek;
    fetch = 1'b1;
`ifdef CONV_SEQ_KERNEL_CACHE_EN
    if (tb_kv && kb == tb_kb) fetch = 1'b0;
`endif
    exp_in_q.delete();
    exp_k_q.delete();
    for (int i = 0; i < NI; i++) begin
      ea = tb + 15'(i);
      exp_in_q.push_back(ea);
      exp_fi[(NI-1-i)*8 +: 8] = ea[7:0];
    end
    if (fetch)
      for (int i = 0; i < NK; i++) begin
        ek = kb + 8'(i);
        exp_k_q.push_back(ek);
        exp_fk[(NK-1-i)*8 +: 8] = ek + 8'h80;
      end
    conv_val = val; tile_base = tb; kernel_base = kb; start = 1'b1;
    cyc = 0; first_in = -1; kicks = 0; kick_cyc = -1; done_cyc = -1;
    while (done_cyc < 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        if (!hold) start = 1'b0;
        tile_base = 15'($urandom); kernel_base = 8'($urandom);
      end
      if (in_en) begin
        if (first_in < 0) first_in = cyc;
        n_checks++;
        if (exp_in_q.size() == 0) begin
          n_fail++; $display("FAIL in_extra: in_addr %h issued, none expected", in_addr);
        end else begin
          ea = exp_in_q.pop_front();
          if (in_addr !== ea) begin
            n_fail++; $display("FAIL in_addr cyc %0d: got %h expected %h", cyc, in_addr, ea);
          end
        end
      end
      if (k_en) begin
        n_checks++;
        if (exp_k_q.size() == 0) begin
          n_fail++; $display("FAIL k_extra: k_addr %h issued, none expected", k_addr);
        end else begin
          ek = exp_k_q.pop_front();
          if (k_addr !== ek) begin
            n_fail++; $display("FAIL k_addr cyc %0d: got %h expected %h", cyc, k_addr, ek);
          end
        end
      end
      if (conv_start) begin kicks++; kick_cyc = cyc; end
      if (done === 1'b1) done_cyc = cyc;
      else begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++; $display("FAIL busy cyc %0d: got %b expected 1", cyc, busy);
        end
      end
    end
    n_checks++;
    if (done_cyc != 56) begin
      n_fail++; $display("FAIL done_cycle: got %0d expected 56 (-1 = timeout)", done_cyc);
    end
    n_checks++;
    if (first_in != 1) begin
      n_fail++; $display("FAIL first_addr_cycle: got %0d expected 1", first_in);
    end
    n_checks++;
    if (exp_in_q.size() != 0 || exp_k_q.size() != 0) begin
      n_fail++; $display("FAIL addr_missing: got %0d/%0d left expected 0/0", exp_in_q.size(), exp_k_q.size());
    end
    n_checks++;
    if (kicks != 1 || kick_cyc != 50) begin
      n_fail++; $display("FAIL conv_start: got %0d pulses last cyc %0d expected 1 at 50", kicks, kick_cyc);
    end
    n_checks++;
    if (result_valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL finish_flags: got rv=%b busy=%b expected rv=1 busy=0", result_valid, busy);
    end
    n_checks++;
    if (result !== val) begin
      n_fail++; $display("FAIL result: got %h expected %h", result, val);
    end
    n_checks++;
    if (flat_input !== exp_fi) begin
      n_fail++; $display("FAIL flat_input: got %h expected %h", flat_input, exp_fi);
    end
    n_checks++;
    if (flat_kernel !== exp_fk) begin
      n_fail++; $display("FAIL flat_kernel: got %h expected %h", flat_kernel, exp_fk);
    end
    tb_kv = 1'b1; tb_kb = kb;
    start = (hold && chain) ? 1'b1 : 1'b0;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || result_valid !== 1'b0 || result !== val) begin
      n_fail++; $display("FAIL after_done: got done=%b rv=%b result=%h expected 0 0 %h", done, result_valid, result, val);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    n_checks++;
    if ({busy, done, result_valid, in_en, k_en, conv_start} !== 6'b0 ||
        in_addr !== '0 || k_addr !== '0 || result !== '0 ||
        flat_input !== '0 || flat_kernel !== '0) begin
      n_fail++;
      $display("FAIL %s: got busy=%b done=%b rv=%b in_en=%b k_en=%b cs=%b in_addr=%h k_addr=%h result=%h fi_or=%b fk_or=%b expected all 0",
               tag, busy, done, result_valid, in_en, k_en, conv_start, in_addr, k_addr, result, |flat_input, |flat_kernel);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; stray = 1'b0; conv_val = '0;
    tile_base = '0; kernel_base = '0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset_state");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_zero("idle_after_release");
  endtask

  task automatic test_basic();
    run_op(15'h0000, 8'h00, 20'h12345, 1'b0, 1'b0);
    n_checks++;
    if (flat_input[383:376] !== 8'h00 || flat_input[7:0] !== 8'h2F ||
        flat_kernel[215:208] !== 8'h80 || flat_kernel[7:0] !== 8'h9A) begin
      n_fail++; $display("FAIL slot_ends: got %h %h %h %h expected 00 2f 80 9a",
                         flat_input[383:376], flat_input[7:0], flat_kernel[215:208], flat_kernel[7:0]);
    end
  endtask

  task automatic test_wrap();
    run_op(15'h7FF0, 8'hF0, 20'h0ABCD, 1'b0, 1'b0);
  endtask

  task automatic test_stray_final();
    conv_val = 20'h55555;
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    n_checks++;
    if (result !== 20'h0ABCD || done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL stray_final: got result=%h done=%b busy=%b expected 0abcd 0 0", result, done, busy);
    end
  endtask

  task automatic test_back_to_back();
    run_op(15'h0100, 8'h33, 20'h11111, 1'b1, 1'b1);
    run_op(15'h0200, 8'h44, 20'h22222, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || in_en !== 1'b0) begin
      n_fail++; $display("FAIL no_third_op: got busy=%b in_en=%b expected 0 0", busy, in_en);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_kick;
    tile_base = 15'h0005; kernel_base = 8'h07; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    n_checks++;
    if (in_en !== 1'b1 || in_addr !== 15'h0018) begin
      n_fail++; $display("FAIL mid_load: got in_en=%b in_addr=%h expected 1 0018", in_en, in_addr);
    end
    reset = 1'b0;
    #1;
    check_idle_zero("async_reset");
    tb_kv = 1'b0; exp_fi = '0; exp_fk = '0;
    saw_kick = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (conv_start) saw_kick = 1'b1;
    end
    n_checks++;
    if (saw_kick) begin
      n_fail++; $display("FAIL aborted_kick: got conv_start pulse expected none");
    end
    run_op(15'h0000, 8'h00, 20'h12345, 1'b0, 1'b0);
  endtask

  task automatic test_kernel_cache();
    run_op(15'h0040, 8'h10, 20'h0AAAA, 1'b0, 1'b0);
    run_op(15'h0080, 8'h10, 20'h0BBBB, 1'b0, 1'b0);
    run_op(15'h00C0, 8'h20, 20'h0CCCC, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stray_final();
    test_back_to_back();
    test_reset_mid();
    test_kernel_cache();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
